// File: rtl/gb_rom_loader.sv
// Packs the IO ROM byte stream into little-endian 16-bit SDRAM writes through a 2-entry FIFO,
// and captures the Game Boy cartridge header (mapper, ROM mask) as the bytes go by.
module gb_rom_loader #(
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            rom_loading,
    input  logic [7:0]            rom_do,
    input  logic                  rom_do_valid,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-2:0] mem_addr,
    output logic [15:0]           mem_din,
    output logic                  busy,
    output logic                  load_done,
    output logic                  header_valid,
    output logic [7:0]            cart_type,
    output logic [7:0]            rom_size,
    output logic [7:0]            ram_size,
    output logic                  cgb_flag,
    output logic [2:0]            mbc,
    output logic [ADDR_WIDTH-1:0] rom_mask,
    output logic [23:0]           byte_count,
    output logic                  overflow
);
    // state | meaning
    // IDLE  | waiting for rom_loading to go nonzero
    // LOAD  | packing incoming bytes into words
    // FLUSH | writing a trailing odd byte, draining the FIFO
    // DONE  | one-cycle completion pulse
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WA = ADDR_WIDTH - 1;
    localparam int EW = WA + 16;

    logic [1:0]    state;
    logic [7:0]    low_byte;
    logic          low_pending;
    logic [EW-1:0] fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    fifo_count;

    logic [31:0]   bc_ext;
    logic          in_range;
    logic          byte_in_load;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [EW-1:0] push_data;
    logic [ADDR_WIDTH-1:0] all_ones;

    assign bc_ext       = {8'd0, byte_count};
    assign in_range     = (bc_ext >> ADDR_WIDTH) == 32'd0;
    assign byte_in_load = (state == ST_LOAD) && rom_do_valid;
    assign pop          = mem_req && mem_ack;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok      = push && ((fifo_count != 2'd2) || pop);

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (byte_in_load && in_range && bc_ext[0]) begin
            push      = 1'b1;
            push_data = {bc_ext[ADDR_WIDTH-1:1], rom_do, low_byte};
        end else if ((state == ST_FLUSH) && low_pending) begin
            push      = 1'b1;
            push_data = {bc_ext[ADDR_WIDTH-1:1], 8'hFF, low_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            low_byte     <= 8'd0;
            low_pending  <= 1'b0;
            byte_count   <= 24'd0;
            cart_type    <= 8'd0;
            rom_size     <= 8'd0;
            ram_size     <= 8'd0;
            cgb_flag     <= 1'b0;
            header_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rom_loading != 8'd0) begin
                        state        <= ST_LOAD;
                        byte_count   <= 24'd0;
                        low_pending  <= 1'b0;
                        cart_type    <= 8'd0;
                        rom_size     <= 8'd0;
                        ram_size     <= 8'd0;
                        cgb_flag     <= 1'b0;
                        header_valid <= 1'b0;
                        overflow     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (rom_do_valid) begin
                        if (byte_count != 24'hFFFFFF) begin
                            byte_count <= byte_count + 24'd1;
                        end
                        if (!in_range) begin
                            overflow <= 1'b1;
                        end else if (!byte_count[0]) begin
                            low_byte    <= rom_do;
                            low_pending <= 1'b1;
                        end else begin
                            low_pending <= 1'b0;
                        end
                        case (byte_count)
                            24'h000143: cgb_flag  <= rom_do[7];
                            24'h000147: cart_type <= rom_do;
                            24'h000148: rom_size  <= rom_do;
                            24'h000149: ram_size  <= rom_do;
                            default: ;
                        endcase
                    end
                    if (rom_loading == 8'd0) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (low_pending) begin
                        low_pending <= 1'b0;
                    end
                    if (rom_do_valid) begin
                        overflow <= 1'b1;
                    end
                    // Finish as soon as the last ack is seen rather than waiting for mem_req to drop.
                    if (!low_pending &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    header_valid <= (byte_count >= 24'h000150);
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Address and data are latched at request start so they hold steady until the ack.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 16'd0;
        end else if (mem_req) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end else if (fifo_count != 2'd0) begin
            mem_req             <= 1'b1;
            {mem_addr, mem_din} <= fifo_mem[rd_ptr];
        end
    end

    assign busy      = (state != ST_IDLE);
    assign load_done = (state == ST_DONE);
    assign all_ones  = '1;

    always_comb begin
        mbc = 3'd7;
        case (cart_type) inside
            8'h00:          mbc = 3'd0;
            [8'h01:8'h03]:  mbc = 3'd1;
            [8'h05:8'h06]:  mbc = 3'd2;
            [8'h0F:8'h13]:  mbc = 3'd3;
            [8'h19:8'h1E]:  mbc = 3'd5;
            default:        mbc = 3'd7;
        endcase
    end

    always_comb begin
        rom_mask = all_ones;
        if (rom_size <= 8'd8) begin
            rom_mask = ~(all_ones << (5'd15 + {1'b0, rom_size[3:0]}));
        end
    end
endmodule
